approx_mult_error_monitor: RTL



---
 rtl/approx_mult_error_monitor.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/approx_mult_error_monitor.sv
// rtl/approx_mult_error_monitor.sv - on-chip error statistics for approximate 16x16 multipliers
// Optional feature macro: AEM_BIAS_EN (signed bias accumulator driving sum_bias).
module approx_mult_error_monitor #(
  parameter int W     = 16,
  parameter int CNT_W = 16,
  parameter int ACC_W = 48
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic [2*W-1:0]     in_p,
  input  logic               clear,
  output logic               busy,
  output logic [CNT_W-1:0]   sample_count,
  output logic [CNT_W-1:0]   err_count,
  output logic [2*W-1:0]     max_err,
  output logic [ACC_W-1:0]   sum_err,
  output logic [ACC_W-1:0]   sum_bias
);

  localparam int HALF = W / 2;
  localparam int IT_W = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_CMP} state_t;

  state_t            state, state_nxt;
  logic [W-1:0]      b_r;
  logic [2*W-1:0]    a_sh;
  logic [2*W-1:0]    p_r;
  logic [2*W-1:0]    acc;
  logic [IT_W-1:0]   iter;
  logic [2*W-1:0]    addend;
  logic [2*W-1:0]    err_mag;
  logic [ACC_W:0]    sum_ext;
  logic              last_iter;
  logic              accept;

  assign last_iter = (iter == IT_W'(HALF - 1));
  assign accept    = (state == S_IDLE) && in_valid && !clear;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; clear aborts anything in flight
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (in_valid) state_nxt = S_MUL;
        S_MUL:   if (last_iter) state_nxt = S_CMP;
        S_CMP:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Handshake outputs depend on state only
  always_comb begin
    in_ready = (state == S_IDLE);
    busy     = (state != S_IDLE);
  end

  // Radix-4 partial product: a_sh already carries the 2i shift, 3A built as A + 2A
  always_comb begin
    case (b_r[1:0])
      2'd0:    addend = '0;
      2'd1:    addend = a_sh;
      2'd2:    addend = a_sh << 1;
      default: addend = a_sh + (a_sh << 1);
    endcase
  end

  // Error magnitude and widened sum for saturation detection
  always_comb begin
    err_mag = (acc >= p_r) ? (acc - p_r) : (p_r - acc);
    sum_ext = {1'b0, sum_err} + (ACC_W + 1)'(err_mag);
  end

  // Operand capture and iterative shift-add datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_r  <= '0;
      p_r  <= '0;
      acc  <= '0;
      iter <= '0;
    end else if (accept) begin
      a_sh <= (2 * W)'(in_a);
      b_r  <= in_b;
      p_r  <= in_p;
      acc  <= '0;
      iter <= '0;
    end else if (state == S_MUL) begin
      acc  <= acc + addend;
      a_sh <= a_sh << 2;
      b_r  <= b_r >> 2;
      iter <= iter + IT_W'(1);
    end
  end

  // Statistics update in CMP; clear wins over a coincident update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_count <= '0;
      err_count    <= '0;
      max_err      <= '0;
      sum_err      <= '0;
    end else if (clear) begin
      sample_count <= '0;
      err_count    <= '0;
      max_err      <= '0;
      sum_err      <= '0;
    end else if (state == S_CMP) begin
      if (sample_count != '1)
        sample_count <= sample_count + CNT_W'(1);
      if ((err_mag != '0) && (err_count != '1))
        err_count <= err_count + CNT_W'(1);
      if (err_mag > max_err)
        max_err <= err_mag;
      sum_err <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
    end
  end

`ifdef AEM_BIAS_EN
  logic signed [2*W:0]     bias_diff;
  logic signed [ACC_W+1:0] bias_diff_ext;
  logic signed [ACC_W+1:0] bias_cur_ext;
  logic signed [ACC_W+1:0] bias_sum;
  logic                    bias_ovf;
  logic [ACC_W-1:0]        bias_r;

  // Signed (P - exact) added with two guard bits, then clamped to the ACC_W signed range
  always_comb begin
    bias_diff     = $signed({1'b0, p_r}) - $signed({1'b0, acc});
    bias_diff_ext = bias_diff;
    bias_cur_ext  = $signed(bias_r);
    bias_sum      = bias_cur_ext + bias_diff_ext;
    bias_ovf      = !((bias_sum[ACC_W+1:ACC_W-1] == 3'b000) ||
                      (bias_sum[ACC_W+1:ACC_W-1] == 3'b111));
  end

  // Bias accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_r <= '0;
    end else if (clear) begin
      bias_r <= '0;
    end else if (state == S_CMP) begin
      if (bias_ovf)
        bias_r <= bias_sum[ACC_W+1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
        bias_r <= bias_sum[ACC_W-1:0];
    end
  end

  assign sum_bias = bias_r;
`else
  assign sum_bias = '0;
`endif

endmodule
